// File: rtl/aes_128_pkg.sv
// rtl/aes_128_pkg.sv - shared AES-128 key-loader types, constants and helpers
package aes_128_pkg;

  localparam int NUM_RK   = 11;
  localparam int RK_IDX_W = 4;
  localparam logic [RK_IDX_W-1:0] LAST_RK = RK_IDX_W'(NUM_RK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_128_sbox.sv
// rtl/aes_128_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_128_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_128_key_loader.sv
// rtl/aes_128_key_loader.sv - expands an AES-128 cipher key and streams the 11 round keys
module aes_128_key_loader
  import aes_128_pkg::*;
#(
  parameter int WR_GAP = 0
) (
  input  logic                clk,
  input  logic                kill_n,
  input  logic                start,
  input  logic [127:0]        key_in,
  input  logic                inv_order,
  output logic                en_wr,
  output logic [127:0]        key_round_wr,
  output logic [RK_IDX_W-1:0] key_round_idx,
  output logic                busy,
  output logic                done,
  output logic                start_collision_irq_pulse
);

  localparam logic [RK_IDX_W-1:0] GAP_INIT = RK_IDX_W'(WR_GAP);

  state_e                state_q, state_d;
  logic [127:0]          rk_q, rk_d;
  logic [RK_IDX_W-1:0]   rnd_q, rnd_d, ptr_q, ptr_d, wcnt_q, wcnt_d, gap_q, gap_d;
  logic [7:0]            rcon_q, rcon_d;
  logic                  inv_q, inv_d;
  logic                  en_wr_q, en_wr_d, busy_q, busy_d, done_q, done_d, irq_q, irq_d;
  logic [127:0]          krw_q, krw_d;
  logic [RK_IDX_W-1:0]   kidx_q, kidx_d;

  logic [127:0]          store_q [NUM_RK];
  logic                  st_we;
  logic [RK_IDX_W-1:0]   st_idx;
  logic [127:0]          st_data;

  // One key-schedule round from the previous round key held in rk_q.
  logic [31:0] rot_w, sub_w, t_w, w0, w1, w2, w3;
  logic [127:0] next_rk;

  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_128_sbox u_sbox (
      .in_byte  (rot_w[8*b +: 8]),
      .out_byte (sub_w[8*b +: 8])
    );
  end

  always_comb begin
    t_w     = sub_w ^ {rcon_q, 24'h0};
    w0      = rk_q[127:96] ^ t_w;
    w1      = rk_q[95:64]  ^ w0;
    w2      = rk_q[63:32]  ^ w1;
    w3      = rk_q[31:0]   ^ w2;
    next_rk = {w0, w1, w2, w3};
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    gap_d   = gap_q;
    rcon_d  = rcon_q;
    inv_d   = inv_q;
    busy_d  = busy_q;
    en_wr_d = 1'b0;
    krw_d   = '0;
    kidx_d  = '0;
    done_d  = 1'b0;
    irq_d   = start && (state_q != ST_IDLE);
    st_we   = 1'b0;
    st_idx  = rnd_q;
    st_data = next_rk;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          st_we   = 1'b1;
          st_idx  = '0;
          st_data = key_in;
          rk_d    = key_in;
          inv_d   = inv_order;
          rnd_d   = RK_IDX_W'(1);
          rcon_d  = RCON[0];
          busy_d  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        st_we  = 1'b1;
        rk_d   = next_rk;
        rnd_d  = rnd_q + 1'b1;
        rcon_d = xtime(rcon_q);
        if (rnd_q == LAST_RK) begin
          ptr_d   = inv_q ? LAST_RK : '0;
          wcnt_d  = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        en_wr_d = 1'b1;
        krw_d   = store_q[ptr_q];
        kidx_d  = ptr_q;
        ptr_d   = inv_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        if (wcnt_q == LAST_RK) begin
          state_d = ST_DONE;
        end else if (WR_GAP > 0) begin
          gap_d   = GAP_INIT;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= RK_IDX_W'(1)) state_d = ST_WRITE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      rnd_q   <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      gap_q   <= '0;
      rcon_q  <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_wr_q <= 1'b0;
      krw_q   <= '0;
      kidx_q  <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
      rcon_q  <= rcon_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      en_wr_q <= en_wr_d;
      krw_q   <= krw_d;
      kidx_q  <= kidx_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  // Store contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (st_we) store_q[st_idx] <= st_data;
  end

  assign en_wr                     = en_wr_q;
  assign key_round_wr              = krw_q;
  assign key_round_idx             = kidx_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign start_collision_irq_pulse = irq_q;

endmodule

// File: tb/tb_aes_128_key_loader.sv
// tb/tb_aes_128_key_loader.sv - self-checking bench for aes_128_key_loader
module tb_aes_128_key_loader;

  typedef struct {
    int           c;
    logic [3:0]   idx;
    logic [127:0] d;
  } wr_rec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } rk_vec_t;

  typedef struct {
    int           pos;
    logic [3:0]   idx;
    logic [127:0] data;
  } pos_vec_t;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         kill_n;
  logic         start [2];
  logic         inv [2];
  logic [127:0] key [2];
  logic         en_wr [2];
  logic [127:0] krw [2];
  logic [3:0]   kidx [2];
  logic         busy [2];
  logic         done [2];
  logic         irq [2];

  always #5 clk = ~clk;

  aes_128_key_loader #(.WR_GAP(0)) u_gap0 (
    .clk(clk), .kill_n(kill_n), .start(start[0]), .key_in(key[0]), .inv_order(inv[0]),
    .en_wr(en_wr[0]), .key_round_wr(krw[0]), .key_round_idx(kidx[0]),
    .busy(busy[0]), .done(done[0]), .start_collision_irq_pulse(irq[0])
  );

  aes_128_key_loader #(.WR_GAP(3)) u_gap3 (
    .clk(clk), .kill_n(kill_n), .start(start[1]), .key_in(key[1]), .inv_order(inv[1]),
    .en_wr(en_wr[1]), .key_round_wr(krw[1]), .key_round_idx(kidx[1]),
    .busy(busy[1]), .done(done[1]), .start_collision_irq_pulse(irq[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = 0;
  int t0 = 0;
  int done_n = 0, done_c = 0, irq_n = 0, zviol = 0;
  wr_rec_t wq[$];
  rk_vec_t fips [11];
  pos_vec_t rev_tab [2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      if (!en_wr[s] && (krw[s] != '0 || kidx[s] != '0)) zviol++;
    if (en_wr[sel]) wq.push_back('{c: cyc, idx: kidx[sel], d: krw[sel]});
    if (done[sel]) begin
      done_n++;
      done_c = cyc;
    end
    if (irq[sel]) irq_n++;
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    done_n = 0;
    done_c = 0;
    irq_n  = 0;
    zviol  = 0;
  endtask

  // Called just after a negedge; key and order are scrambled after acceptance.
  task automatic do_start(int s, logic [127:0] k, logic v);
    start[s] = 1'b1;
    key[s]   = k;
    inv[s]   = v;
    @(posedge clk);
    #1;
    t0       = cyc;
    start[s] = 1'b0;
    key[s]   = ~k;
    inv[s]   = ~v;
  endtask

  task automatic wait_done(string nm, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_n > 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 128'(ok), 128'(1));
  endtask

  task automatic check_fwd(string tag, int gap);
    chk({tag, "_count"}, 128'(wq.size()), 128'(11));
    for (int i = 0; i < 11 && i < wq.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), 128'(wq[i].idx), 128'(fips[i].idx));
      chk($sformatf("%s_data%0d", tag, i), wq[i].d, fips[i].data);
      chk($sformatf("%s_cyc%0d", tag, i), 128'(wq[i].c - t0), 128'(11 + i * (gap + 1)));
    end
    chk({tag, "_busy_span"}, 128'(done_c - t0 + 1), 128'(23 + 10 * gap));
    chk({tag, "_done_once"}, 128'(done_n), 128'(1));
    chk({tag, "_zero_idle"}, 128'(zviol), 128'(0));
  endtask

  initial begin
    int viol;
    bit ok;

    fips[0]  = '{4'd0,  K1};
    fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    rev_tab[0] = '{0,  4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    rev_tab[1] = '{10, 4'd0,  K2};

    kill_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      inv[s]   = 1'b0;
      key[s]   = '0;
    end

    // Test 1: reset and idle
    repeat (3) @(negedge clk);
    chk("reset_en_wr", 128'(en_wr[0]), 128'(0));
    chk("reset_busy", 128'(busy[0] | busy[1]), 128'(0));
    kill_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      for (int s = 0; s < 2; s++)
        if (en_wr[s] || busy[s] || done[s] || irq[s] || krw[s] != '0 || kidx[s] != '0) viol++;
    end
    chk("idle_outputs_zero", 128'(viol), 128'(0));

    // Test 2: forward, no gap
    sel = 0;
    clr();
    do_start(0, K1, 1'b0);
    chk("t2_busy_after_start", 128'(busy[0]), 128'(1));
    wait_done("t2", 60);
    chk("t2_busy_at_done", 128'(busy[0]), 128'(0));
    check_fwd("t2", 0);
    chk("t2_no_irq", 128'(irq_n), 128'(0));

    // Test 3: reverse order
    @(negedge clk);
    #1;
    clr();
    do_start(0, K2, 1'b1);
    wait_done("t3", 60);
    chk("t3_count", 128'(wq.size()), 128'(11));
    for (int i = 0; i < 11 && i < wq.size(); i++)
      chk($sformatf("t3_idx%0d", i), 128'(wq[i].idx), 128'(10 - i));
    for (int j = 0; j < 2; j++)
      if (rev_tab[j].pos < wq.size()) begin
        chk($sformatf("t3_pos%0d_idx", rev_tab[j].pos), 128'(wq[rev_tab[j].pos].idx), 128'(rev_tab[j].idx));
        chk($sformatf("t3_pos%0d_data", rev_tab[j].pos), wq[rev_tab[j].pos].d, rev_tab[j].data);
      end

    // Test 4: WR_GAP=3 instance
    sel = 1;
    @(negedge clk);
    #1;
    clr();
    do_start(1, K1, 1'b0);
    wait_done("t4", 120);
    check_fwd("t4", 3);

    // Test 5: start collisions in EXPAND and WRITE, then start on the done cycle
    sel = 0;
    @(negedge clk);
    #1;
    clr();
    do_start(0, K1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    start[0] = 1'b1; key[0] = '0; inv[0] = 1'b1;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wq.size() >= 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("t5_reach_write", 128'(ok), 128'(1));
    start[0] = 1'b1; key[0] = K2; inv[0] = 1'b1;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    wait_done("t5", 60);
    check_fwd("t5", 0);
    chk("t5_irq_count", 128'(irq_n), 128'(2));
    clr();
    do_start(0, K1, 1'b0);
    wait_done("t5b", 60);
    check_fwd("t5b", 0);
    chk("t5b_no_irq", 128'(irq_n), 128'(0));

    // Test 6: kill after the 5th write, then a full restart
    @(negedge clk);
    #1;
    clr();
    do_start(0, K1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (wq.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_five_writes", 128'(ok), 128'(1));
    kill_n = 1'b0;
    #1;
    chk("t6_en_wr_drop", 128'(en_wr[0]), 128'(0));
    chk("t6_busy_drop", 128'(busy[0]), 128'(0));
    repeat (5) @(negedge clk);
    #1;
    kill_n = 1'b1;
    chk("t6_no_done", 128'(done_n), 128'(0));
    chk("t6_writes_stopped", 128'(wq.size()), 128'(5));
    @(negedge clk);
    #1;
    clr();
    do_start(0, K1, 1'b0);
    wait_done("t6b", 60);
    check_fwd("t6b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
